// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and the probe channel state encoding.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = $clog2(NREGS);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } probe_state_t;

endpackage

// File: rtl/probe_chan.sv
// One probe channel: picks a register byte lane and hands it downstream over valid/ready.
// state | meaning
// IDLE  | no data outstanding; live mode watches for change, hold mode waits for trigger
// PEND  | out_data held with out_valid high until the consumer takes it
module probe_chan
    import cpu_pkg::*;
#(
    parameter int XLEN   = cpu_pkg::XLEN,
    parameter int NREGS  = cpu_pkg::NREGS,
    parameter int OUT_W  = 8,
    localparam int SEL_W  = $clog2(NREGS),
    localparam int LANES  = XLEN / OUT_W,
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   regs [NREGS],
    input  logic [SEL_W-1:0]  sel,
    input  logic [LANE_W-1:0] lane,
    input  logic              mode,
    input  logic              trig,
    input  logic              out_ready,
    input  logic              ovr_clr,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    output logic              overrun
);

    probe_state_t     state_q, state_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic [OUT_W-1:0] last_q, last_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic [XLEN-1:0]  word;
    logic [OUT_W-1:0] sample;

    always_comb begin
        word   = regs[sel];
        sample = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane == LANE_W'(i)) sample = word[i*OUT_W +: OUT_W];
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (ovr_clr) ovr_d = 1'b0;
        case (state_q)
            IDLE: begin
                if ((!mode && sample != last_q) || (mode && trig)) begin
                    data_d  = sample;
                    valid_d = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                // A hold trigger here is lost even on the handshake cycle; set beats clear.
                if (mode && trig) ovr_d = 1'b1;
                if (valid_q && out_ready) begin
                    last_d  = data_q;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;

endmodule

// File: rtl/reg_probe.sv
// Register-file observation unit: trigger synchroniser/edge detector plus N_CH probe channels.
module reg_probe
    import cpu_pkg::*;
#(
    parameter int XLEN        = cpu_pkg::XLEN,
    parameter int NREGS       = cpu_pkg::NREGS,
    parameter int N_CH        = 2,
    parameter int OUT_W       = 8,
    parameter int SYNC_STAGES = 2,
    localparam int SEL_W  = $clog2(NREGS),
    localparam int LANES  = XLEN / OUT_W,
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         trigger_in,
    output logic                         trigger_pulse,
    input  logic [XLEN-1:0]              regs [NREGS],
    input  logic [N_CH-1:0][SEL_W-1:0]   ch_sel,
    input  logic [N_CH-1:0][LANE_W-1:0]  ch_lane,
    input  logic [N_CH-1:0]              mode,
    output logic [N_CH-1:0][OUT_W-1:0]   out_data,
    output logic [N_CH-1:0]              out_valid,
    input  logic [N_CH-1:0]              out_ready,
    output logic [N_CH-1:0]              overrun,
    input  logic [N_CH-1:0]              ovr_clr
);

    if ((XLEN % OUT_W) != 0 || SYNC_STAGES < 2) begin : g_param_check
        $error("reg_probe: XLEN must be a multiple of OUT_W and SYNC_STAGES >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   pulse_q, pulse_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], trigger_in};
        prev_d  = sync_q[SYNC_STAGES-1];
        pulse_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign trigger_pulse = pulse_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        probe_chan #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .OUT_W (OUT_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .regs      (regs),
            .sel       (ch_sel[g]),
            .lane      (ch_lane[g]),
            .mode      (mode[g]),
            .trig      (pulse_q),
            .out_ready (out_ready[g]),
            .ovr_clr   (ovr_clr[g]),
            .out_data  (out_data[g]),
            .out_valid (out_valid[g]),
            .overrun   (overrun[g])
        );
    end

endmodule

// File: tb/tb_reg_probe.sv
// Directed bench for reg_probe: trigger pulse, live/hold transfers, backpressure, overrun, reset.
module tb_reg_probe;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              trigger_in;
    logic              trigger_pulse;
    logic [31:0]       regs [32];
    logic [1:0][4:0]   ch_sel;
    logic [1:0][1:0]   ch_lane;
    logic [1:0]        mode;
    logic [1:0][7:0]   out_data;
    logic [1:0]        out_valid;
    logic [1:0]        out_ready;
    logic [1:0]        overrun;
    logic [1:0]        ovr_clr;

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    reg_probe dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .trigger_in    (trigger_in),
        .trigger_pulse (trigger_pulse),
        .regs          (regs),
        .ch_sel        (ch_sel),
        .ch_lane       (ch_lane),
        .mode          (mode),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .overrun       (overrun),
        .ovr_clr       (ovr_clr)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        trigger_in = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        ch_sel    = '0;
        ch_lane   = '0;
        mode      = '0;
        out_ready = '1;
        ovr_clr   = '0;
        #2;
        tests_run++;
        if (out_valid !== 2'b00) begin fails++; $display("FAIL reset_valid got %b want 00", out_valid); end
        tests_run++;
        if (out_data !== 16'h0) begin fails++; $display("FAIL reset_data got %h want 0000", out_data); end
        tests_run++;
        if (overrun !== 2'b00) begin fails++; $display("FAIL reset_overrun got %b want 00", overrun); end
        tests_run++;
        if (trigger_pulse !== 1'b0) begin fails++; $display("FAIL reset_pulse got %b want 0", trigger_pulse); end
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_trigger();
        int cnt   = 0;
        int first = -1;
        trigger_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (trigger_pulse === 1'b1) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        tests_run++;
        if (cnt !== 1) begin fails++; $display("FAIL trig_count got %0d want 1", cnt); end
        tests_run++;
        if (first !== 3) begin fails++; $display("FAIL trig_latency got %0d want 3", first); end
        trigger_in = 1'b0;
        tick(5);
        trigger_in = 1'b1;
        cnt = 0;
        repeat (10) begin
            tick(1);
            if (trigger_pulse === 1'b1) cnt++;
        end
        tests_run++;
        if (cnt !== 1) begin fails++; $display("FAIL trig_recount got %0d want 1", cnt); end
        trigger_in = 1'b0;
        tick(4);
    endtask

    task automatic test_live();
        int cnt = 0;
        ch_sel[0]  = 5'd10;
        ch_lane[0] = 2'd0;
        mode[0]    = 1'b0;
        regs[10]   = 32'h0000_00A5;
        tick(1);
        tests_run++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== 8'hA5) begin
            fails++; $display("FAIL live_xfer got v=%b d=%h want v=1 d=a5", out_valid[0], out_data[0]);
        end
        tick(1);
        tests_run++;
        if (out_valid[0] !== 1'b0) begin fails++; $display("FAIL live_accept got v=%b want 0", out_valid[0]); end
        repeat (5) begin
            tick(1);
            if (out_valid[0] === 1'b1) cnt++;
        end
        tests_run++;
        if (cnt !== 0) begin fails++; $display("FAIL live_quiet got %0d valids want 0", cnt); end
    endtask

    task automatic test_backpressure();
        regs[10] = 32'h0;
        tick(2);
        out_ready[0] = 1'b0;
        regs[10]     = 32'h0000_00A5;
        tick(1);
        tests_run++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== 8'hA5) begin
            fails++; $display("FAIL bp_start got v=%b d=%h want v=1 d=a5", out_valid[0], out_data[0]);
        end
        regs[10] = 32'h0000_003C;
        tick(1);
        tests_run++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== 8'hA5) begin
            fails++; $display("FAIL bp_hold1 got v=%b d=%h want v=1 d=a5", out_valid[0], out_data[0]);
        end
        regs[10] = 32'h0000_0077;
        tick(1);
        tests_run++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== 8'hA5) begin
            fails++; $display("FAIL bp_hold2 got v=%b d=%h want v=1 d=a5", out_valid[0], out_data[0]);
        end
        out_ready[0] = 1'b1;
        tick(1);
        tests_run++;
        if (out_valid[0] !== 1'b0) begin fails++; $display("FAIL bp_accept got v=%b want 0", out_valid[0]); end
        tick(1);
        tests_run++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h77) begin
            fails++; $display("FAIL bp_next got v=%b d=%h want v=1 d=77", out_valid[0], out_data[0]);
        end
        tests_run++;
        if (overrun[0] !== 1'b0) begin fails++; $display("FAIL bp_overrun got %b want 0", overrun[0]); end
        tick(2);
    endtask

    task automatic test_hold();
        int cnt = 0;
        int k   = 0;
        ch_sel[1]    = 5'd20;
        ch_lane[1]   = 2'd2;
        mode[1]      = 1'b1;
        out_ready[1] = 1'b1;
        regs[20]     = 32'h1234_5678;
        repeat (5) begin
            tick(1);
            if (out_valid[1] === 1'b1) cnt++;
        end
        tests_run++;
        if (cnt !== 0) begin fails++; $display("FAIL hold_idle got %0d valids want 0", cnt); end
        trigger_in = 1'b1;
        while (out_valid[1] !== 1'b1 && k < 10) begin
            tick(1);
            k++;
        end
        tests_run++;
        if (out_valid[1] !== 1'b1 || out_data[1] !== 8'h34) begin
            fails++; $display("FAIL hold_capture got v=%b d=%h want v=1 d=34", out_valid[1], out_data[1]);
        end
        trigger_in = 1'b0;
        tick(4);
    endtask

    task automatic test_overrun();
        int k = 0;
        out_ready[1] = 1'b0;
        trigger_in   = 1'b1;
        while (out_valid[1] !== 1'b1 && k < 10) begin
            tick(1);
            k++;
        end
        tests_run++;
        if (out_valid[1] !== 1'b1 || out_data[1] !== 8'h34) begin
            fails++; $display("FAIL ovr_first got v=%b d=%h want v=1 d=34", out_valid[1], out_data[1]);
        end
        regs[20]   = 32'hAABB_CCDD;
        trigger_in = 1'b0;
        tick(3);
        trigger_in = 1'b1;
        tick(6);
        tests_run++;
        if (overrun[1] !== 1'b1) begin fails++; $display("FAIL ovr_set got %b want 1", overrun[1]); end
        tests_run++;
        if (out_valid[1] !== 1'b1 || out_data[1] !== 8'h34) begin
            fails++; $display("FAIL ovr_keep got v=%b d=%h want v=1 d=34", out_valid[1], out_data[1]);
        end
        ovr_clr[1] = 1'b1;
        tick(1);
        ovr_clr[1] = 1'b0;
        tests_run++;
        if (overrun[1] !== 1'b0) begin fails++; $display("FAIL ovr_clear got %b want 0", overrun[1]); end
        // Third rise lands its pulse exactly on the cycle ovr_clr is high.
        trigger_in = 1'b0;
        tick(3);
        trigger_in = 1'b1;
        tick(3);
        tests_run++;
        if (trigger_pulse !== 1'b1) begin fails++; $display("FAIL ovr_pulse_align got %b want 1", trigger_pulse); end
        ovr_clr[1] = 1'b1;
        tick(1);
        ovr_clr[1] = 1'b0;
        tests_run++;
        if (overrun[1] !== 1'b1) begin fails++; $display("FAIL ovr_set_wins got %b want 1", overrun[1]); end
        trigger_in = 1'b0;
        ovr_clr[1] = 1'b1;
        out_ready[1] = 1'b1;
        tick(1);
        ovr_clr[1] = 1'b0;
        tick(3);
    endtask

    task automatic test_reset_mid();
        out_ready[0] = 1'b0;
        regs[10]     = 32'h0000_005A;
        tick(1);
        tests_run++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h5A) begin
            fails++; $display("FAIL rst_mid_pend got v=%b d=%h want v=1 d=5a", out_valid[0], out_data[0]);
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid[0] !== 1'b0 || out_data[0] !== 8'h00) begin
            fails++; $display("FAIL rst_mid_async got v=%b d=%h want v=0 d=00", out_valid[0], out_data[0]);
        end
        rst_n = 1'b1;
        tick(1);
        tests_run++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h5A) begin
            fails++; $display("FAIL rst_first_xfer got v=%b d=%h want v=1 d=5a", out_valid[0], out_data[0]);
        end
        out_ready[0] = 1'b1;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_live();
        test_backpressure();
        test_hold();
        test_overrun();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
